// File: rtl/mips_cpu_regfile_write_arbiter.sv
// Register-file write-port arbiter: merges ALU writebacks with buffered load
// returns onto a single write port and tracks pending-load destinations in a
// busy-bit scoreboard for decode.
module mips_cpu_regfile_write_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alu_valid,
    input  logic [4:0]                      alu_reg,
    input  logic [31:0]                     alu_data,
    output logic                            alu_ready,
    input  logic                            mem_valid,
    input  logic [4:0]                      mem_reg,
    input  logic [31:0]                     mem_data,
    input  logic                            issue_valid,
    input  logic [4:0]                      issue_reg,
    input  logic [4:0]                      query_reg_1,
    input  logic [4:0]                      query_reg_2,
    output logic                            busy_1,
    output logic                            busy_2,
    output logic                            write_enable,
    output logic [4:0]                      write_reg,
    output logic [31:0]                     write_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            mem_overflow
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic LAST_FIFO = 1'b0;
    localparam logic LAST_ALU  = 1'b1;

    logic [4:0]    buf_reg  [FIFO_DEPTH];
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          last;
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    logic          fifo_req;
    logic          fifo_full;
    logic          grant_fifo;
    logic          grant_alu;
    logic          enq;
    logic          drop;
    logic [4:0]    head_reg;
    logic [31:0]   head_data;

    assign fifo_req  = (count != '0);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign head_reg  = buf_reg[rd_ptr];
    assign head_data = buf_data[rd_ptr];

    // Single-winner arbitration: full buffer wins outright, otherwise alternate
    always_comb begin
        grant_fifo = 1'b0;
        grant_alu  = 1'b0;
        if (!reset) begin
            if (fifo_req && alu_valid) begin
                if (fifo_full || (last == LAST_ALU)) begin
                    grant_fifo = 1'b1;
                end else begin
                    grant_alu = 1'b1;
                end
            end else if (fifo_req) begin
                grant_fifo = 1'b1;
            end else if (alu_valid) begin
                grant_alu = 1'b1;
            end
        end
    end

    assign alu_ready = grant_alu;

    // A full buffer always drains in the same cycle, so a slot frees up for arrivals
    assign enq  = mem_valid && !reset && (!fifo_full || grant_fifo);
    assign drop = mem_valid && !reset && fifo_full && !grant_fifo;

    // Scoreboard update: clear on load writeback, then set on issue so set wins
    always_comb begin
        busy_next = busy;
        if (grant_fifo) begin
            busy_next[head_reg] = 1'b0;
        end
        if (issue_valid && (issue_reg != 5'd0)) begin
            busy_next[issue_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign busy_1     = busy[query_reg_1];
    assign busy_2     = busy[query_reg_2];
    assign fifo_count = count;

    // Load-return storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_reg[wr_ptr]  <= mem_reg;
            buf_data[wr_ptr] <= mem_data;
        end
    end

    // Control state, scoreboard and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            last         <= LAST_FIFO;
            busy         <= '0;
            mem_overflow <= 1'b0;
            write_enable <= 1'b0;
            write_reg    <= 5'd0;
            write_data   <= 32'd0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (grant_fifo) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(enq) - CW'(grant_fifo);
            busy  <= busy_next;
            if (drop) begin
                mem_overflow <= 1'b1;
            end

            if (grant_fifo) begin
                last         <= LAST_FIFO;
                write_enable <= (head_reg != 5'd0);
                write_reg    <= head_reg;
                write_data   <= head_data;
            end else if (grant_alu) begin
                last         <= LAST_ALU;
                write_enable <= (alu_reg != 5'd0);
                write_reg    <= alu_reg;
                write_data   <= alu_data;
            end else begin
                write_enable <= 1'b0;
                write_reg    <= 5'd0;
                write_data   <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_regfile_write_arbiter.sv
// Bench for the register-file write arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_mips_cpu_regfile_write_arbiter;

    localparam int unsigned DEPTH = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       alu_valid;
    logic [4:0]                 alu_reg;
    logic [31:0]                alu_data;
    logic                       alu_ready;
    logic                       mem_valid;
    logic [4:0]                 mem_reg;
    logic [31:0]                mem_data;
    logic                       issue_valid;
    logic [4:0]                 issue_reg;
    logic [4:0]                 query_reg_1;
    logic [4:0]                 query_reg_2;
    logic                       busy_1;
    logic                       busy_2;
    logic                       write_enable;
    logic [4:0]                 write_reg;
    logic [31:0]                write_data;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic                       mem_overflow;

    mips_cpu_regfile_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_reg      (mem_reg),
        .mem_data     (mem_data),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .query_reg_1  (query_reg_1),
        .query_reg_2  (query_reg_2),
        .busy_1       (busy_1),
        .busy_2       (busy_2),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .fifo_count   (fifo_count),
        .mem_overflow (mem_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit [31:0]   mbusy = '0;
    bit          m_alu_was_last = 1'b0;
    bit          movf = 1'b0;
    bit          mwe = 1'b0;
    logic [4:0]  mwr = '0;
    logic [31:0] mwd = '0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who wins this cycle according to the arbitration rules
    function automatic void model_grant(output bit gf, output bit ga);
        gf = 1'b0;
        ga = 1'b0;
        if (reset) return;
        if (mq.size() != 0 && alu_valid) begin
            if (mq.size() == DEPTH || m_alu_was_last) gf = 1'b1;
            else ga = 1'b1;
        end else if (mq.size() != 0) begin
            gf = 1'b1;
        end else if (alu_valid) begin
            ga = 1'b1;
        end
    endfunction

    task automatic check_model();
        bit gf, ga;
        model_grant(gf, ga);
        chk("alu_ready", 32'(alu_ready), 32'(ga));
        chk("busy_1", 32'(busy_1), 32'(mbusy[query_reg_1]));
        chk("busy_2", 32'(busy_2), 32'(mbusy[query_reg_2]));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("mem_overflow", 32'(mem_overflow), 32'(movf));
        chk("write_enable", 32'(write_enable), 32'(mwe));
        if (mwe) begin
            chk("write_reg", 32'(write_reg), 32'(mwr));
            chk("write_data", write_data, mwd);
        end
    endtask

    task automatic model_update();
        bit   gf, ga;
        ent_t e;
        model_grant(gf, ga);
        if (reset) begin
            mq.delete();
            mbusy = '0;
            movf = 1'b0;
            m_alu_was_last = 1'b0;
            mwe = 1'b0;
            mwr = '0;
            mwd = '0;
            return;
        end
        mwe = 1'b0;
        if (gf) begin
            e = mq.pop_front();
            mbusy[e.r] = 1'b0;
            mwe = (e.r != 0);
            mwr = e.r;
            mwd = e.d;
            m_alu_was_last = 1'b0;
        end else if (ga) begin
            mwe = (alu_reg != 0);
            mwr = alu_reg;
            mwd = alu_data;
            m_alu_was_last = 1'b1;
        end
        if (mem_valid) begin
            if (mq.size() < DEPTH) begin
                e.r = mem_reg;
                e.d = mem_data;
                mq.push_back(e);
            end else begin
                movf = 1'b1;
            end
        end
        if (issue_valid && issue_reg != 0) mbusy[issue_reg] = 1'b1;
        mbusy[0] = 1'b0;
    endtask

    task automatic drive(input bit rst, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md,
                         input bit iv, input logic [4:0] ir,
                         input logic [4:0] q1, input logic [4:0] q2);
        reset       = rst;
        alu_valid   = av;
        alu_reg     = ar;
        alu_data    = ad;
        mem_valid   = mv;
        mem_reg     = mr;
        mem_data    = md;
        issue_valid = iv;
        issue_reg   = ir;
        query_reg_1 = q1;
        query_reg_2 = q2;
    endtask

    // Drive at the falling edge, then compare once outputs have settled
    task automatic apply(input bit rst, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md,
                         input bit iv, input logic [4:0] ir,
                         input logic [4:0] q1, input logic [4:0] q2);
        drive(rst, av, ar, ad, mv, mr, md, iv, ir, q1, q2);
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset holds off the ALU, then the write port reads zero
        apply(1, 1, 5'd5, 32'h1, 1, 5'd3, 32'h3, 1, 5'd3, 5'd3, 5'd0);
        chk("reset_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        chk("reset_count", 32'(fifo_count), 32'd0);
        chk("reset_we", 32'(write_enable), 32'd0);
        chk("reset_wr", 32'(write_reg), 32'd0);
        chk("reset_wd", write_data, 32'd0);
        chk("reset_ovf", 32'(mem_overflow), 32'd0);
        chk("reset_busy3", 32'(busy_1), 32'd0);
        tick();

        // Lone ALU request is granted at once, written next cycle
        apply(0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_only_ready", 32'(alu_ready), 32'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 0);
        chk("alu_only_we", 32'(write_enable), 32'd1);
        chk("alu_only_wr", 32'(write_reg), 32'd5);
        chk("alu_only_wd", write_data, 32'h1234);
        tick();

        // Load to r8: busy until grant edge, write two cycles after return
        apply(0, 0, 0, 0, 1, 5'd8, 32'hCAFE, 0, 0, 5'd8, 0);
        chk("load_busy_issue", 32'(busy_1), 32'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 0);
        chk("load_busy_queued", 32'(busy_1), 32'd1);
        chk("load_count", 32'(fifo_count), 32'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd8, 0);
        chk("load_we", 32'(write_enable), 32'd1);
        chk("load_wr", 32'(write_reg), 32'd8);
        chk("load_wd", write_data, 32'hCAFE);
        chk("load_busy_clear", 32'(busy_1), 32'd0);
        tick();

        // Round robin with last=FIFO: ALU, then FIFO, then ALU
        apply(0, 0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0, 0);
        tick();
        apply(0, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_first_alu", 32'(alu_ready), 32'd1);
        tick();
        apply(0, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_then_fifo", 32'(alu_ready), 32'd0);
        chk("rr_alu_wr", 32'(write_reg), 32'd3);
        tick();
        apply(0, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
        chk("rr_alu_again", 32'(alu_ready), 32'd1);
        chk("rr_fifo_wr", 32'(write_reg), 32'd9);
        chk("rr_fifo_wd", write_data, 32'h99);
        tick();

        // Back-to-back loads with ALU held: buffer fills, full stalls the ALU
        apply(0, 1, 5'd2, 32'h22, 1, 5'd10, 32'hA0, 1, 5'd4, 0, 0);
        chk("bb_c1_ready", 32'(alu_ready), 32'd1);
        tick();
        apply(0, 1, 5'd2, 32'h22, 1, 5'd11, 32'hA1, 1, 5'd7, 0, 0);
        chk("bb_c2_ready", 32'(alu_ready), 32'd0);
        tick();
        apply(0, 1, 5'd2, 32'h22, 1, 5'd12, 32'hA2, 0, 0, 0, 0);
        chk("bb_c3_ready", 32'(alu_ready), 32'd1);
        tick();
        apply(0, 1, 5'd2, 32'h22, 1, 5'd13, 32'hA3, 0, 0, 0, 0);
        chk("bb_full_count", 32'(fifo_count), 32'd2);
        chk("bb_full_stall", 32'(alu_ready), 32'd0);
        tick();
        apply(0, 1, 5'd2, 32'h22, 1, 5'd14, 32'hA4, 0, 0, 5'd4, 5'd7);
        chk("bb_full_accept_count", 32'(fifo_count), 32'd2);
        chk("bb_full_stall2", 32'(alu_ready), 32'd0);
        chk("bb_no_overflow", 32'(mem_overflow), 32'd0);
        chk("bb_busy4", 32'(busy_1), 32'd1);
        chk("bb_busy7", 32'(busy_2), 32'd1);
        tick();

        // Reset with a full buffer and busy bits discards everything
        apply(1, 1, 5'd2, 32'h22, 1, 5'd15, 32'hA5, 1, 5'd9, 5'd4, 5'd7);
        chk("rst2_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd7);
        chk("rst2_count", 32'(fifo_count), 32'd0);
        chk("rst2_busy1", 32'(busy_1), 32'd0);
        chk("rst2_busy2", 32'(busy_2), 32'd0);
        chk("rst2_we", 32'(write_enable), 32'd0);
        chk("rst2_ovf", 32'(mem_overflow), 32'd0);
        tick();

        // Register 0: write consumed without enable, never marked busy
        apply(0, 1, 5'd0, 32'hDEAD, 0, 0, 0, 1, 5'd0, 5'd0, 0);
        chk("r0_ready", 32'(alu_ready), 32'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        chk("r0_we", 32'(write_enable), 32'd0);
        chk("r0_busy", 32'(busy_1), 32'd0);
        tick();

        // Same-edge clear and re-issue of r6 leaves it busy
        apply(0, 0, 0, 0, 1, 5'd6, 32'h66, 1, 5'd6, 5'd6, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 1, 5'd6, 5'd6, 0);
        chk("setclr_before", 32'(busy_1), 32'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd6, 0);
        chk("setclr_after", 32'(busy_1), 32'd1);
        chk("setclr_we", 32'(write_enable), 32'd1);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            apply(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
